// File: rtl/mem_req_ctrl.sv
// Cache-side main-memory initiator: runs one fill, writeback or writeback-then-fill
// command at a time, with a line-range check and a response timeout.
module mem_req_ctrl #(
   parameter int ENTRIES = 256,
   parameter int TIMEOUT = 15,
   parameter int TW      = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_fill,
   input  logic         req_wb,
   input  logic [26:0]  req_fill_addr,
   input  logic [26:0]  req_wb_addr,
   input  logic [255:0] req_wb_data,
   input  logic [31:0]  req_wb_be,
   output logic         fill_valid,
   output logic [255:0] fill_data,
   output logic         done,
   output logic         err,
   output logic [1:0]   err_code,
   output logic [26:0]  mem_a,
   output logic [31:0]  mem_be,
   output logic [255:0] mem_wd,
   output logic         mem_write,
   output logic         mem_read,
   input  logic [255:0] mem_rd,
   input  logic         mem_valid,
   input  logic         mem_ready
);

   typedef enum logic [2:0] {
      IDLE,
      WB_REQ,
      WB_WAIT,
      FILL_REQ,
      FILL_WAIT,
      DONE
   } state_t;

   localparam logic [27:0]   LIMIT   = 28'(ENTRIES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   state_t        state_reg;
   logic [TW-1:0] cnt_reg;
   logic          fill_pend_reg;
   logic [26:0]   fill_addr_reg;
   logic          range_err;

   always_comb begin
      range_err = (req_wb   && ({1'b0, req_wb_addr}   >= LIMIT)) ||
                  (req_fill && ({1'b0, req_fill_addr} >= LIMIT));
   end

   // The writeback fields are captured straight into the mem_* registers,
   // which also hold them stable for the whole write handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         fill_pend_reg <= 1'b0;
         fill_addr_reg <= '0;
         req_ready     <= 1'b1;
         fill_valid    <= 1'b0;
         fill_data     <= '0;
         done          <= 1'b0;
         err           <= 1'b0;
         err_code      <= 2'd0;
         mem_a         <= '0;
         mem_be        <= '0;
         mem_wd        <= '0;
         mem_write     <= 1'b0;
         mem_read      <= 1'b0;
      end else begin
         fill_valid <= 1'b0;
         done       <= 1'b0;
         mem_write  <= 1'b0;
         mem_read   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready     <= 1'b0;
                  fill_pend_reg <= req_fill;
                  fill_addr_reg <= req_fill_addr;
                  if (range_err) begin
                     if (!err) begin
                        err      <= 1'b1;
                        err_code <= 2'd1;
                     end
                     state_reg <= DONE;
                  end else if (req_wb) begin
                     mem_write <= 1'b1;
                     mem_a     <= req_wb_addr;
                     mem_wd    <= req_wb_data;
                     mem_be    <= req_wb_be;
                     state_reg <= WB_REQ;
                  end else if (req_fill) begin
                     mem_read  <= 1'b1;
                     mem_a     <= req_fill_addr;
                     mem_be    <= '0;
                     state_reg <= FILL_REQ;
                  end else begin
                     state_reg <= DONE;
                  end
               end
            end
            WB_REQ: begin
               cnt_reg   <= '0;
               state_reg <= WB_WAIT;
            end
            WB_WAIT: begin
               if (mem_ready) begin
                  if (fill_pend_reg) begin
                     mem_read  <= 1'b1;
                     mem_a     <= fill_addr_reg;
                     mem_be    <= '0;
                     state_reg <= FILL_REQ;
                  end else begin
                     done      <= 1'b1;
                     state_reg <= DONE;
                  end
               end else if (cnt_reg == TO_LAST) begin
                  if (!err) begin
                     err      <= 1'b1;
                     err_code <= 2'd2;
                  end
                  done      <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + TW'(1);
               end
            end
            FILL_REQ: begin
               cnt_reg   <= '0;
               state_reg <= FILL_WAIT;
            end
            FILL_WAIT: begin
               if (mem_valid) begin
                  fill_data  <= mem_rd;
                  fill_valid <= 1'b1;
                  done       <= 1'b1;
                  state_reg  <= DONE;
               end else if (cnt_reg == TO_LAST) begin
                  if (!err) begin
                     err      <= 1'b1;
                     err_code <= 2'd2;
                  end
                  done      <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + TW'(1);
               end
            end
            DONE: begin
               // Entered straight from IDLE (no memory access), done is not yet
               // raised, so it is pulsed one cycle later before returning to IDLE.
               if (done) begin
                  req_ready <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  done <= 1'b1;
               end
            end
            default: begin
               req_ready <= 1'b1;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Cache-side initiator for the main-memory port: 256-bit line, 27-bit line address, 32-bit byte enables, single-cycle read/write strobes, valid/ready returns.
- Accepts one miss-handling command at a time from the cache controller: fill only, writeback only, or writeback-then-fill (dirty eviction).
- Sequences the memory strobes, holds address and data stable until the memory responds, and returns fill data.
- Adds a range check and a response timeout so a hung or out-of-range access raises an error instead of stalling the cache.

Parameters:
- ENTRIES, 256, number of valid memory lines; any line address >= ENTRIES is out of range.
- TIMEOUT, 15, maximum cycles to wait for valid/ready after a strobe before flagging an error.
- TW, 4, timeout counter width; TIMEOUT must be < 2**TW.

Ports:
- clk  in  1  clock, all flops rise-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command present.
- req_ready  out  1  controller idle, command accepted when req_valid&req_ready.
- req_fill  in  1  command includes line read.
- req_wb  in  1  command includes line writeback (performed first).
- req_fill_addr  in  27  fill line address.
- req_wb_addr  in  27  writeback line address.
- req_wb_data  in  256  writeback line data.
- req_wb_be  in  32  writeback byte enables.
- fill_valid  out  1  one-cycle pulse, fill_data valid.
- fill_data  out  256  registered fill line.
- done  out  1  one-cycle pulse, command finished (ok or error).
- err  out  1  sticky error, cleared only by reset.
- err_code  out  2  0 none, 1 out of range, 2 timeout; holds the first error.
- mem_a  out  27  memory line address.
- mem_be  out  32  memory byte enables.
- mem_wd  out  256  memory write data.
- mem_write  out  1  write strobe.
- mem_read  out  1  read strobe.
- mem_rd  in  256  memory read data.
- mem_valid  in  1  read data valid.
- mem_ready  in  1  write complete.

Behaviour:
- Reset values: all outputs 0, except req_ready=1. State IDLE. Command and timeout registers cleared. Reset mid-command abandons it: no done, no fill_valid.
- States: IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, DONE.
- IDLE: req_ready=1. On accept, all command fields are captured into registers.
  - req_wb=1: go to WB_REQ.
  - Only req_fill=1: go to FILL_REQ.
  - Neither set: go to DONE (no memory access).
- Range check at accept: if any requested address is >= ENTRIES, set err with code 1, issue no memory strobe, and go to DONE.
- WB_REQ: for exactly one cycle drive mem_write=1, mem_a=wb_addr, mem_wd=wb_data, mem_be=wb_be. Then go to WB_WAIT.
- WB_WAIT:
  - mem_write=0. mem_a, mem_wd and mem_be are held stable; memory samples wd one cycle after the strobe.
  - Leave when mem_ready=1, expected 2 cycles after the strobe. Go to FILL_REQ if fill is pending, else DONE.
- FILL_REQ: for exactly one cycle drive mem_read=1, mem_a=fill_addr, mem_be=0. Then go to FILL_WAIT.
- FILL_WAIT:
  - mem_a is held.
  - On mem_valid=1 (expected 2 cycles after the strobe), register fill_data<=mem_rd and go to DONE.
- DONE: fill_valid pulses if a fill completed; done pulses. Then go to IDLE.
  - Minimum latency, fill only: accept at edge 0, done high in cycle 4.
  - Writeback+fill: done high in cycle 7.
- Strobe rules:
  - Strobes are never high on consecutive cycles; the memory ignores back-to-back strobes.
  - mem_read and mem_write are never both high.
- Timeout: a counter resets on entry to each WAIT state and increments each WAIT cycle. Reaching TIMEOUT without a response sets err (code 2) and goes to DONE with no fill_valid.
- Unexpected mem_valid or mem_ready outside the matching WAIT state is ignored.
- The mem_* outputs are registered; no combinational path from req_* to mem_*.

Test Plan:
- Fill-only of addr 0x05 (memory preloaded 0xA5..A5) -> mem_read high one cycle, fill_valid+done in cycle 4, fill_data=0xA5..A5, req_ready low cycles 1-4.
- Writeback+fill: wb addr 0x03, data 0x1234.., be=all ones, fill addr 0x03 -> write strobe, then read strobe 3 cycles later, fill_data=0x1234.., done in cycle 7.
- Out of range: fill addr 256 with ENTRIES=256 -> no mem strobes, err=1, err_code=1, done in cycle 2.
- Timeout: memory model that never asserts valid -> done after TIMEOUT wait cycles, err_code=2, no fill_valid.
- Reset asserted during WB_WAIT -> all outputs zero immediately, req_ready=1; the next fill command completes normally.
- Back-to-back commands with req_valid held high -> the second is accepted only in the cycle after done; strobes are never adjacent.
